lock_ctrl: RTL



---
 rtl/lock_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/lock_ctrl.sv
// lock_ctrl: downstream stage of the serial combination-lock checker.
//
// Watches the checker's UNLOCK / NG levels for rising edges. It opens the
// door for a fixed time on a successful unlock, counts failed entries, and
// after MAX_TRIES failures holds a timed lockout. A one-cycle restart pulse
// goes back to the checker whenever an entry attempt is finished.
//
// Optional feature (macro LOCK_ALARM_EN): a strike flag remembers that one
// lockout has already expired. Reaching lockout again before a successful
// unlock latches a permanent ALARM state that only rst clears.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   unlock     checker UNLOCK level (rising edge = combination matched)
//   vg         checker VG level (correct bit entered)
//   ng         checker NG level (rising edge = wrong bit entered)
//   door_open  actuator drive (registered)
//   lockout    high while locked out or in alarm (registered)
//   clr_entry  one-cycle restart pulse to the checker (registered)
//   tries_left failures remaining before lockout (registered)
//   busy_entry vg & ~ng sampled while ARMED, status LED (registered)
//   alarm      only with LOCK_ALARM_EN: latched alarm indication (registered)
module lock_ctrl #(
    parameter int MAX_TRIES      = 3,
    parameter int OPEN_CYCLES    = 16,
    parameter int LOCKOUT_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       unlock,
    input  logic       vg,
    input  logic       ng,
    output logic       door_open,
    output logic       lockout,
    output logic       clr_entry,
    output logic [3:0] tries_left,
`ifdef LOCK_ALARM_EN
    output logic       alarm,
`endif
    output logic       busy_entry
);

    localparam int MAX_CYC = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2,
        ALARM   = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic [3:0]      tries_reg, tries_next;
    logic            door_reg, door_next;
    logic            lock_reg, lock_next;
    logic            clr_reg, clr_next;
    logic            busy_reg, busy_next;
    logic            unlock_q_reg, ng_q_reg;
    logic            unlock_rise, ng_rise;
    logic            clr_event;
`ifdef LOCK_ALARM_EN
    logic            strike_reg, strike_next;
    logic            alarm_reg, alarm_next;
`endif

    assign unlock_rise = unlock & ~unlock_q_reg;
    assign ng_rise     = ng & ~ng_q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ARMED;
            timer_reg    <= '0;
            tries_reg    <= 4'(MAX_TRIES);
            door_reg     <= 1'b0;
            lock_reg     <= 1'b0;
            clr_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            // History starts high so levels held through reset are not edges.
            unlock_q_reg <= 1'b1;
            ng_q_reg     <= 1'b1;
`ifdef LOCK_ALARM_EN
            strike_reg   <= 1'b0;
            alarm_reg    <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            tries_reg    <= tries_next;
            door_reg     <= door_next;
            lock_reg     <= lock_next;
            clr_reg      <= clr_next;
            busy_reg     <= busy_next;
            unlock_q_reg <= unlock;
            ng_q_reg     <= ng;
`ifdef LOCK_ALARM_EN
            strike_reg   <= strike_next;
            alarm_reg    <= alarm_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        timer_next  = timer_reg;
        tries_next  = tries_reg;
        clr_event   = 1'b0;
`ifdef LOCK_ALARM_EN
        strike_next = strike_reg;
`endif
        case (state_reg)
            ARMED: begin
                // Unlock has priority over a same-cycle failure.
                if (unlock_rise) begin
                    state_next = OPEN;
                    timer_next = TW'(OPEN_CYCLES - 1);
                    tries_next = 4'(MAX_TRIES);
`ifdef LOCK_ALARM_EN
                    strike_next = 1'b0;
`endif
                end else if (ng_rise) begin
                    clr_event = 1'b1;
                    if (tries_reg > 4'd1) begin
                        tries_next = tries_reg - 4'd1;
                    end else begin
                        tries_next = 4'd0;
                        timer_next = TW'(LOCKOUT_CYCLES - 1);
`ifdef LOCK_ALARM_EN
                        state_next = strike_reg ? ALARM : LOCKOUT;
`else
                        state_next = LOCKOUT;
`endif
                    end
                end
            end
            OPEN: begin
                if (timer_reg == '0) begin
                    state_next = ARMED;
                    clr_event  = 1'b1;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            LOCKOUT: begin
                if (timer_reg == '0) begin
                    state_next = ARMED;
                    tries_next = 4'(MAX_TRIES);
                    clr_event  = 1'b1;
`ifdef LOCK_ALARM_EN
                    strike_next = 1'b1;
`endif
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            default: begin
                // ALARM: latched until reset; every edge is ignored.
                state_next = state_reg;
            end
        endcase

        // A restart pulse directly after another one would be back-to-back;
        // the checker is already restarting, so the second request is merged.
        clr_next  = clr_event & ~clr_reg;
        door_next = (state_next == OPEN);
        lock_next = (state_next == LOCKOUT) || (state_next == ALARM);
        busy_next = (state_reg == ARMED) & vg & ~ng;
`ifdef LOCK_ALARM_EN
        alarm_next = (state_next == ALARM);
`endif
    end

    assign door_open  = door_reg;
    assign lockout    = lock_reg;
    assign clr_entry  = clr_reg;
    assign tries_left = tries_reg;
    assign busy_entry = busy_reg;
`ifdef LOCK_ALARM_EN
    assign alarm      = alarm_reg;
`endif

endmodule
